dff_stim_gen: RTL and testbench
===============================

Name: dff_stim_gen

Overview:
- Synthesizable stimulus driver for a D flip-flop with synchronous active-low reset; it is the driving end of the FF's d/reset_n interface.
- Sequence per run:
  - Hold the DUT in reset while toggling d at pseudo-random intervals.
  - Release reset and toggle d again at pseudo-random intervals.
  - Re-assert reset.
- Sits in front of the d_ff_sync_rstn-style cell, for on-board self-exercise and for FPGA bring-up without a simulator.

Parameters:
- TOGGLES_PER_PHASE, 5: number of d toggles in each of the HOLD and RUN phases (1..15).
- LFSR_WIDTH, 8: width of the pseudo-random generator.
- SEED, 8'hA5: LFSR reset value; a value of 0 is replaced by 1.
- DELAY_BITS, 2: inter-toggle delay = lfsr[DELAY_BITS-1:0] + 1 cycles, giving a 1..4 cycle range by default.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- q_in  in  1  DUT q output, used only with the checker feature.
- d_out  out  1  drives DUT d.
- reset_n_out  out  1  drives DUT reset_n; active low.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle pulse at end of run.
- phase  out  2  current phase: 0 IDLE, 1 HOLD, 2 RUN, 3 REASSERT/DONE.
- err  out  1  sticky mismatch flag; tied 0 unless the checker is compiled in.

Behaviour:
- Reset (async, any state):
  - state=IDLE, d_out=0, reset_n_out=0, busy=0, done=0, err=0.
  - LFSR=SEED, delay counter=0, toggle counter=0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts exactly once per delay-counter load, never otherwise, so the sequence is deterministic per SEED.
- Delay-counter load: value = lfsr[DELAY_BITS-1:0]+1, taken before the shift.
- Delay counting:
  - Counter decrements every cycle.
  - At the edge where the counter equals 1: d_out inverts, toggle counter increments, and the delay counter reloads.
  - A toggle therefore occurs exactly D edges after its load.
- IDLE:
  - reset_n_out=0, busy=0.
  - start=1 → HOLD; load delay counter; busy=1 from the next cycle.
- HOLD:
  - reset_n_out=0.
  - After the TOGGLES_PER_PHASE-th toggle → RUN, clear toggle counter, load delay counter.
  - reset_n_out=1 from the first RUN cycle.
- RUN:
  - reset_n_out=1.
  - After the TOGGLES_PER_PHASE-th toggle → REASSERT.
- REASSERT:
  - reset_n_out=0 for exactly one cycle, then DONE.
- DONE:
  - done=1 for one cycle, busy=1 in that cycle, then IDLE with busy=0.
  - d_out keeps its last value; its parity equals (2*TOGGLES_PER_PHASE) mod 2, i.e. 0.
- start while busy: ignored, no queueing.
- start in the same cycle as reset: reset wins.
- Reset mid-run: abort immediately to reset values; a later start replays the identical sequence from SEED.
- All outputs are registered; no combinational path from start to any output.

Optional Feature:
- Macro: DFF_STIM_CHECKER_EN.
- With the macro defined, a reference model runs every cycle:
  - exp_q <= reset_n_out ? d_out : 0, i.e. the same sampling as the DUT.
  - Compare q_in to exp_q one cycle later, in every non-IDLE state.
  - Any mismatch sets err; err clears only on reset.
- Without the macro: err is constant 0, q_in is unused, and no checker logic is present.

Decomposition:
- Package dff_stim_pkg:
  - State encoding: IDLE=3'd0, HOLD=3'd1, RUN=3'd2, REASSERT=3'd3, DONE=3'd4.
  - phase output mapping.
  - LFSR tap mask 8'hB8.
  - Default SEED constant.
- Sub-module lfsr_gen:
  - Ports clk, reset, advance, value.
  - Parameters WIDTH, SEED, TAPS.
  - Instantiated once; the top level holds the FSM, counters and checker.

Test Plan:
- Reset then start=1 for one cycle with SEED=8'hA5 → busy=1 next cycle, reset_n_out=0, first d_out toggle exactly 2 edges after start (lfsr[1:0]=01).
- Full run, default parameters → exactly 5 toggles with reset_n_out=0, then 5 with reset_n_out=1, then one cycle reset_n_out=0, one-cycle done, every gap between toggles in 1..4 cycles, final d_out=0.
- start pulsed repeatedly while busy → no restart, run length identical to an undisturbed run.
- reset asserted during RUN after the 3rd toggle → all outputs at reset values asynchronously; a subsequent start reproduces a cycle-identical sequence.
- DFF_STIM_CHECKER_EN defined, with the real DFF on q_in → err stays 0 for a full run.
- DFF_STIM_CHECKER_EN defined, with q_in forced to 1 during HOLD → err=1 within 2 cycles and stays 1 until reset.

Source files
------------

// File: rtl/dff_stim_pkg.sv
// rtl/dff_stim_pkg.sv - shared state encoding, phase mapping and LFSR constants for dff_stim_gen
package dff_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_REASSERT = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_HOLD = 2'd1;
    localparam logic [1:0] PHASE_RUN  = 2'd2;
    localparam logic [1:0] PHASE_END  = 2'd3;

    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            ST_IDLE: phase_of = PHASE_IDLE;
            ST_HOLD: phase_of = PHASE_HOLD;
            ST_RUN:  phase_of = PHASE_RUN;
            default: phase_of = PHASE_END;
        endcase
    endfunction

endpackage

// File: rtl/dff_stim_gen_lfsr.sv
// rtl/dff_stim_gen_lfsr.sv - Fibonacci LFSR that steps only when advance is high
module lfsr_gen
    import dff_stim_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    // An all-zero state would lock the register up, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic feedback;

    assign feedback = ^(value & TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED_EFF;
        end else if (advance) begin
            value <= {value[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/dff_stim_gen.sv
// rtl/dff_stim_gen.sv - reset/d stimulus sequencer for a sync-reset DFF; optional checker under DFF_STIM_CHECKER_EN
module dff_stim_gen
    import dff_stim_pkg::*;
#(
    parameter int                    TOGGLES_PER_PHASE = 5,
    parameter int                    LFSR_WIDTH        = 8,
    parameter logic [LFSR_WIDTH-1:0] SEED              = LFSR_WIDTH'(DEFAULT_SEED),
    parameter int                    DELAY_BITS        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q_in,
    output logic       d_out,
    output logic       reset_n_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase,
    output logic       err
);

    localparam int DW = DELAY_BITS + 1;

    state_t                  state;
    state_t                  next_state;
    logic [DW-1:0]           delay_cnt;
    logic [3:0]              toggle_cnt;
    logic [LFSR_WIDTH-1:0]   lfsr_value;
    logic                    active;
    logic                    accept;
    logic                    tick;
    logic                    last_toggle;
    logic                    load;
    logic [DW-1:0]           load_value;

    logic                    busy_d;
    logic                    done_d;
    logic                    reset_n_d;
    logic [1:0]              phase_d;

    assign active      = (state == ST_HOLD) || (state == ST_RUN);
    assign accept      = (state == ST_IDLE) && start;
    assign tick        = active && (delay_cnt == DW'(1));
    assign last_toggle = tick && (toggle_cnt == 4'(TOGGLES_PER_PHASE - 1));
    assign load        = accept || tick;
    // Delay is taken from the LFSR before it shifts on this same edge.
    assign load_value  = DW'(lfsr_value[DELAY_BITS-1:0]) + DW'(1);

    lfsr_gen #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED),
        .TAPS  (LFSR_WIDTH'(LFSR_TAPS))
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (load),
        .value   (lfsr_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start)       next_state = ST_HOLD;
            ST_HOLD:     if (last_toggle) next_state = ST_RUN;
            ST_RUN:      if (last_toggle) next_state = ST_REASSERT;
            ST_REASSERT:                  next_state = ST_DONE;
            ST_DONE:                      next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so nothing reaches a pin combinationally.
    always_comb begin
        busy_d    = (next_state != ST_IDLE);
        done_d    = (next_state == ST_DONE);
        reset_n_d = (next_state == ST_RUN);
        phase_d   = phase_of(next_state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            reset_n_out <= 1'b0;
            phase       <= PHASE_IDLE;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            reset_n_out <= reset_n_d;
            phase       <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_cnt  <= '0;
            toggle_cnt <= '0;
            d_out      <= 1'b0;
        end else begin
            if (load) begin
                delay_cnt <= load_value;
            end else if (active && (delay_cnt != '0)) begin
                delay_cnt <= delay_cnt - DW'(1);
            end

            if (accept || last_toggle) begin
                toggle_cnt <= '0;
            end else if (tick) begin
                toggle_cnt <= toggle_cnt + 4'd1;
            end

            if (tick) begin
                d_out <= ~d_out;
            end
        end
    end

`ifdef DFF_STIM_CHECKER_EN
    logic exp_q;

    // exp_q mirrors the DFF's own sampling, so it is compared with q_in on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            exp_q <= reset_n_out ? d_out : 1'b0;
            if ((state != ST_IDLE) && (q_in != exp_q)) begin
                err <= 1'b1;
            end
        end
    end

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_value[LFSR_WIDTH-1:DELAY_BITS];
`else
    assign err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{lfsr_value[LFSR_WIDTH-1:DELAY_BITS], q_in};
`endif

endmodule

// File: tb/tb_dff_stim_gen.sv
// tb/tb_dff_stim_gen.sv - directed self-checking bench for dff_stim_gen
module tb_dff_stim_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       q_in;
    logic       d_out;
    logic       reset_n_out;
    logic       busy;
    logic       done;
    logic [1:0] phase;
    logic       err;

    int checks = 0;
    int failures = 0;

    // Toggle edges after the start edge for SEED=A5: delays 2,3,2,3,1 | 2,4,4,3,2
    int tog_edge[10] = '{2, 5, 7, 10, 11, 13, 17, 21, 24, 26};

    logic dff_q = 1'b0;
    logic force_one = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) dff_q <= reset_n_out ? d_out : 1'b0;
    assign q_in = force_one ? 1'b1 : dff_q;

    dff_stim_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .q_in        (q_in),
        .d_out       (d_out),
        .reset_n_out (reset_n_out),
        .busy        (busy),
        .done        (done),
        .phase       (phase),
        .err         (err)
    );

    function automatic logic [5:0] obs();
        return {busy, done, phase, reset_n_out, d_out};
    endfunction

    // {busy, done, phase, reset_n, d} expected after edge k (edge 0 samples start)
    function automatic logic [5:0] exp_vec(input int k);
        int n = 0;
        logic [5:0] v;
        for (int i = 0; i < 10; i++) if (tog_edge[i] <= k) n++;
        v[0]   = n[0];
        v[1]   = (k >= 11) && (k < 26);
        v[3:2] = (k < 11) ? 2'd1 : (k < 26) ? 2'd2 : (k < 28) ? 2'd3 : 2'd0;
        v[4]   = (k == 27);
        v[5]   = (k <= 27);
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        checks++;
        if (obs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b0);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_toggle();
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if ({busy, reset_n_out, d_out} !== 3'b100) begin
            failures++;
            $display("FAIL first_busy got=%b exp=100", {busy, reset_n_out, d_out});
        end
        cycle();
        checks++;
        if (d_out !== 1'b0) begin
            failures++;
            $display("FAIL first_no_early_toggle got=%b exp=0", d_out);
        end
        cycle();
        checks++;
        if (d_out !== 1'b1) begin
            failures++;
            $display("FAIL first_toggle_edge2 got=%b exp=1", d_out);
        end
        repeat (30) cycle();
    endtask

    task automatic test_full_run();
        logic [5:0] prev;
        int hold_cnt = 0;
        int run_cnt = 0;
        int last_edge = 0;
        int bad_gaps = 0;
        do_reset();
        prev = obs();
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
            checks++;
            if (obs() !== exp_vec(k)) begin
                failures++;
                $display("FAIL full_run k=%0d got=%b exp=%b", k, obs(), exp_vec(k));
            end
            if (d_out !== prev[0]) begin
                if (prev[1] == 1'b0 && prev[3:2] == 2'd1) hold_cnt++;
                if (prev[1] == 1'b1 && prev[3:2] == 2'd2) run_cnt++;
                if (k - last_edge < 1 || k - last_edge > 4) bad_gaps++;
                last_edge = k;
            end
            prev = obs();
        end
        checks++;
        if (hold_cnt !== 5) begin
            failures++;
            $display("FAIL hold_toggles got=%0d exp=5", hold_cnt);
        end
        checks++;
        if (run_cnt !== 5) begin
            failures++;
            $display("FAIL run_toggles got=%0d exp=5", run_cnt);
        end
        checks++;
        if (bad_gaps !== 0) begin
            failures++;
            $display("FAIL toggle_gaps got=%0d bad exp=0", bad_gaps);
        end
        checks++;
        if (d_out !== 1'b0) begin
            failures++;
            $display("FAIL final_d got=%b exp=0", d_out);
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        start = 1'b1;
        for (int k = 0; k < 34; k++) begin
            cycle();
            start = (k <= 27) ? (k % 3 != 2) : 1'b0;
            checks++;
            if (obs() !== exp_vec(k)) begin
                failures++;
                $display("FAIL busy_start k=%0d got=%b exp=%b", k, obs(), exp_vec(k));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
            checks++;
            if (obs() !== exp_vec(k)) begin
                failures++;
                $display("FAIL mid_run_pre k=%0d got=%b exp=%b", k, obs(), exp_vec(k));
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({obs(), err} !== 7'b0) begin
            failures++;
            $display("FAIL async_abort got=%b exp=%b", {obs(), err}, 7'b0);
        end
        cycle();
        reset = 1'b0;
        cycle();
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
            checks++;
            if (obs() !== exp_vec(k)) begin
                failures++;
                $display("FAIL replay k=%0d got=%b exp=%b", k, obs(), exp_vec(k));
            end
        end
    endtask

    task automatic test_reset_with_start();
        reset = 1'b1;
        start = 1'b1;
        cycle();
        checks++;
        if (obs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_wins got=%b exp=%b", obs(), 6'b0);
        end
        start = 1'b0;
        reset = 1'b0;
        cycle();
        checks++;
        if (obs() !== 6'b0) begin
            failures++;
            $display("FAIL reset_wins_after got=%b exp=%b", obs(), 6'b0);
        end
    endtask

`ifdef DFF_STIM_CHECKER_EN
    task automatic test_checker_clean();
        do_reset();
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL checker_clean got=%b exp=0", err);
        end
    endtask

    task automatic test_checker_fault();
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        force_one = 1'b1;
        cycle();
        cycle();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL checker_detect got=%b exp=1", err);
        end
        force_one = 1'b0;
        repeat (30) cycle();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL checker_sticky got=%b exp=1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL checker_clear got=%b exp=0", err);
        end
    endtask
`else
    task automatic test_err_tied();
        do_reset();
        force_one = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            if (k == 0) start = 1'b0;
        end
        force_one = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_tied got=%b exp=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_toggle();
        test_full_run();
        test_start_while_busy();
        test_reset_mid_run();
        test_reset_with_start();
`ifdef DFF_STIM_CHECKER_EN
        test_checker_clean();
        test_checker_fault();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
